// File: rtl/tx_resp_arbiter.sv
// -----------------------------------------------------------------------------
// tx_resp_arbiter
//
// Schedules responses from the system controller into the UART TX FIFO write
// port. Register-file read bytes and ALU results are held in single-entry
// slots. The two slots are arbitrated round-robin and sent as byte writes.
// An ALU result always goes out as an unbroken low-byte/high-byte pair.
// Writes stall while the FIFO reports full.
//
// Parameters
//   DATA_WIDTH   : byte width of the register file and TX FIFO (8)
//   ALU_WIDTH    : ALU result width, must equal 2*DATA_WIDTH (16)
//
// Ports
//   clk          : system clock
//   rst          : asynchronous reset, active low
//   rf_rd_data   : register-file read data
//   rf_rd_vld    : one-cycle pulse, rf_rd_data valid
//   alu_out      : ALU result
//   alu_out_vld  : one-cycle pulse, alu_out valid
//   fifo_full    : TX FIFO full (write-domain synchronised)
//   err_clr      : clears ovf_err
//   fifo_wr_data : byte presented to the FIFO
//   fifo_wr_en   : FIFO write strobe (combinational from state and fifo_full)
//   busy         : a response is pending or being transferred
//   ovf_err      : sticky, a response was dropped because its slot was full
// -----------------------------------------------------------------------------
module tx_resp_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_vld,
  input  logic [ALU_WIDTH-1:0]  alu_out,
  input  logic                  alu_out_vld,
  input  logic                  fifo_full,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  fifo_wr_en,
  output logic                  busy,
  output logic                  ovf_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_RF = 2'd1,
    SEND_LO = 2'd2,
    SEND_HI = 2'd3
  } state_e;

  // Identifies which source was granted most recently.
  localparam logic GRANT_RF  = 1'b0;
  localparam logic GRANT_ALU = 1'b1;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] rf_slot_q, rf_slot_d;
  logic                  rf_pend_q, rf_pend_d;
  logic [ALU_WIDTH-1:0]  alu_slot_q, alu_slot_d;
  logic                  alu_pend_q, alu_pend_d;
  logic                  ovf_err_q, ovf_err_d;

  // Asserted in the cycle the last byte of a response is accepted.
  logic                  rf_release;
  logic                  alu_release;

  logic                  rf_free, rf_capture, rf_drop;
  logic                  alu_free, alu_capture, alu_drop;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_ALU;  // RF wins the first tie
      rf_slot_q    <= '0;
      rf_pend_q    <= 1'b0;
      alu_slot_q   <= '0;
      alu_pend_q   <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rf_slot_q    <= rf_slot_d;
      rf_pend_q    <= rf_pend_d;
      alu_slot_q   <= alu_slot_d;
      alu_pend_q   <= alu_pend_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration / send FSM and FIFO write port
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rf_release   = 1'b0;
    alu_release  = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;

    case (state_q)
      IDLE: begin
        if (rf_pend_q && alu_pend_q) begin
          // Tie: the source that was not granted last goes first.
          if (last_grant_q == GRANT_ALU) begin
            state_d      = SEND_RF;
            last_grant_d = GRANT_RF;
          end else begin
            state_d      = SEND_LO;
            last_grant_d = GRANT_ALU;
          end
        end else if (rf_pend_q) begin
          state_d      = SEND_RF;
          last_grant_d = GRANT_RF;
        end else if (alu_pend_q) begin
          state_d      = SEND_LO;
          last_grant_d = GRANT_ALU;
        end
      end

      SEND_RF: begin
        fifo_wr_data = rf_slot_q;
        if (!fifo_full) begin
          fifo_wr_en = 1'b1;
          rf_release = 1'b1;
          state_d    = IDLE;
        end
      end

      SEND_LO: begin
        fifo_wr_data = alu_slot_q[DATA_WIDTH-1:0];
        if (!fifo_full) begin
          fifo_wr_en = 1'b1;
          state_d    = SEND_HI;
        end
      end

      SEND_HI: begin
        // The FSM goes straight from LO to HI, so no RF byte can be placed
        // between the two halves of an ALU result.
        fifo_wr_data = alu_slot_q[2*DATA_WIDTH-1:DATA_WIDTH];
        if (!fifo_full) begin
          fifo_wr_en  = 1'b1;
          alu_release = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slot capture and overflow detection
  // ---------------------------------------------------------------------------
  // A slot whose last byte is accepted this cycle counts as free. A new
  // response can then load at the same edge without a lost cycle. The old
  // byte is still on fifo_wr_data, because the slot register only changes
  // at the edge.
  always_comb begin
    rf_free     = !rf_pend_q || rf_release;
    rf_capture  = rf_rd_vld && rf_free;
    rf_drop     = rf_rd_vld && !rf_free;

    alu_free    = !alu_pend_q || alu_release;
    alu_capture = alu_out_vld && alu_free;
    alu_drop    = alu_out_vld && !alu_free;

    rf_slot_d   = rf_slot_q;
    rf_pend_d   = rf_pend_q;
    if (rf_capture) begin
      rf_slot_d = rf_rd_data;
      rf_pend_d = 1'b1;
    end else if (rf_release) begin
      rf_pend_d = 1'b0;
    end

    alu_slot_d  = alu_slot_q;
    alu_pend_d  = alu_pend_q;
    if (alu_capture) begin
      alu_slot_d = alu_out;
      alu_pend_d = 1'b1;
    end else if (alu_release) begin
      alu_pend_d = 1'b0;
    end

    // A drop in the same cycle as err_clr leaves the flag set, so the
    // new drop is not hidden.
    ovf_err_d = ovf_err_q;
    if (rf_drop || alu_drop) begin
      ovf_err_d = 1'b1;
    end else if (err_clr) begin
      ovf_err_d = 1'b0;
    end
  end

  assign busy    = (state_q != IDLE) || rf_pend_q || alu_pend_q;
  assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for tx_resp_arbiter.
// Inputs are driven 1 time unit after the rising edge. Every accepted FIFO
// write is logged at the falling edge, together with its cycle number. Each
// test compares the log against a hand-computed list of bytes and cycle
// offsets. Cycle offsets are counted from the cycle in which the test's
// first vld pulse is driven.
// -----------------------------------------------------------------------------
module tb_tx_resp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_vld;
  logic [15:0] alu_out;
  logic        alu_out_vld;
  logic        fifo_full;
  logic        err_clr;
  logic [7:0]  fifo_wr_data;
  logic        fifo_wr_en;
  logic        busy;
  logic        ovf_err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  logic [7:0] log_data[$];
  int         log_cyc[$];

  tx_resp_arbiter #(
    .DATA_WIDTH(8),
    .ALU_WIDTH (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rf_rd_data  (rf_rd_data),
    .rf_rd_vld   (rf_rd_vld),
    .alu_out     (alu_out),
    .alu_out_vld (alu_out_vld),
    .fifo_full   (fifo_full),
    .err_clr     (err_clr),
    .fifo_wr_data(fifo_wr_data),
    .fifo_wr_en  (fifo_wr_en),
    .busy        (busy),
    .ovf_err     (ovf_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      log_data.push_back(fifo_wr_data);
      log_cyc.push_back(cyc);
      $display("[cyc %0d] write 0x%02h", cyc, fifo_wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic log_clear();
    log_data.delete();
    log_cyc.delete();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; rf_rd_data = 8'h00; rf_rd_vld = 1'b0; alu_out = 16'h0000;
    alu_out_vld = 1'b0; fifo_full = 1'b0; err_clr = 1'b0;
    #2;
    vec_cnt++;
    if ({fifo_wr_en, fifo_wr_data, busy, ovf_err} !== 11'b0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got en=%b data=%h busy=%b ovf=%b, expected all 0",
               fifo_wr_en, fifo_wr_data, busy, ovf_err);
    end
    // Pulses while held in reset must not be captured.
    tick();
    rf_rd_data = 8'hEE; rf_rd_vld = 1'b1; alu_out = 16'hEEEE; alu_out_vld = 1'b1;
    tick();
    rf_rd_vld = 1'b0; alu_out_vld = 1'b0;
    rst = 1'b1;
    tick();
    vec_cnt++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_no_capture: got busy=%b en=%b, expected 0 0", busy, fifo_wr_en);
    end
    $display("test_reset done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_rf_read();
    int t0;
    logic b[6];
    log_clear();
    t0 = cyc;
    rf_rd_data = 8'h5A; rf_rd_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b[i] = busy;
      tick();
      rf_rd_vld = 1'b0;
    end
    vec_cnt++;
    if (log_data.size() != 1) begin
      err_cnt++;
      $display("FAIL rf_read_count: got %0d writes, expected 1", log_data.size());
    end else begin
      vec_cnt++;
      if (log_data[0] !== 8'h5A || log_cyc[0] - t0 != 2) begin
        err_cnt++;
        $display("FAIL rf_read_byte: got 0x%02h at +%0d, expected 0x5a at +2",
                 log_data[0], log_cyc[0] - t0);
      end
    end
    vec_cnt++;
    if (b[0] !== 1'b0 || b[1] !== 1'b1 || b[2] !== 1'b1 || b[3] !== 1'b0) begin
      err_cnt++;
      $display("FAIL rf_read_busy: got %b%b%b%b (cyc0..3), expected 0110",
               b[0], b[1], b[2], b[3]);
    end
    $display("test_rf_read done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_alu_result();
    int t0;
    logic [7:0] ed[$];
    int ec[$];
    ed = '{8'h34, 8'h12};
    ec = '{2, 3};
    log_clear();
    t0 = cyc;
    alu_out = 16'h1234; alu_out_vld = 1'b1;
    tick();
    alu_out_vld = 1'b0;
    repeat (5) tick();
    vec_cnt++;
    if (log_data.size() != ed.size()) begin
      err_cnt++;
      $display("FAIL alu_count: got %0d writes, expected %0d", log_data.size(), ed.size());
    end
    for (int i = 0; i < ed.size() && i < log_data.size(); i++) begin
      vec_cnt++;
      if (log_data[i] !== ed[i] || log_cyc[i] - t0 != ec[i]) begin
        err_cnt++;
        $display("FAIL alu_byte%0d: got 0x%02h at +%0d, expected 0x%02h at +%0d",
                 i, log_data[i], log_cyc[i] - t0, ed[i], ec[i]);
      end
    end
    vec_cnt++;
    if (ovf_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL alu_ovf: got %b, expected 0", ovf_err);
    end
    $display("test_alu_result done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_tie_round_robin();
    int t0;
    logic [7:0] ed[$];
    int ec[$];

    // First tie after reset: RF wins (last grant resets to ALU).
    ed = '{8'hA1, 8'hEF, 8'hBE};
    ec = '{2, 4, 5};
    log_clear();
    t0 = cyc;
    rf_rd_data = 8'hA1; rf_rd_vld = 1'b1; alu_out = 16'hBEEF; alu_out_vld = 1'b1;
    tick();
    rf_rd_vld = 1'b0; alu_out_vld = 1'b0;
    repeat (7) tick();
    vec_cnt++;
    if (log_data.size() != ed.size()) begin
      err_cnt++;
      $display("FAIL tie1_count: got %0d writes, expected %0d", log_data.size(), ed.size());
    end
    for (int i = 0; i < ed.size() && i < log_data.size(); i++) begin
      vec_cnt++;
      if (log_data[i] !== ed[i] || log_cyc[i] - t0 != ec[i]) begin
        err_cnt++;
        $display("FAIL tie1_byte%0d: got 0x%02h at +%0d, expected 0x%02h at +%0d",
                 i, log_data[i], log_cyc[i] - t0, ed[i], ec[i]);
      end
    end

    // Lone RF response: the last grant now records RF.
    log_clear();
    t0 = cyc;
    rf_rd_data = 8'h55; rf_rd_vld = 1'b1;
    tick();
    rf_rd_vld = 1'b0;
    repeat (4) tick();
    vec_cnt++;
    if (log_data.size() != 1 || log_data[0] !== 8'h55 || log_cyc[0] - t0 != 2) begin
      err_cnt++;
      $display("FAIL rf_single: got %0d writes first=0x%02h, expected one 0x55 at +2",
               log_data.size(), (log_data.size() > 0) ? log_data[0] : 8'h00);
    end

    // Repeated tie: ALU goes first this time.
    ed = '{8'hFE, 8'hCA, 8'hA2};
    ec = '{2, 3, 5};
    log_clear();
    t0 = cyc;
    rf_rd_data = 8'hA2; rf_rd_vld = 1'b1; alu_out = 16'hCAFE; alu_out_vld = 1'b1;
    tick();
    rf_rd_vld = 1'b0; alu_out_vld = 1'b0;
    repeat (7) tick();
    vec_cnt++;
    if (log_data.size() != ed.size()) begin
      err_cnt++;
      $display("FAIL tie2_count: got %0d writes, expected %0d", log_data.size(), ed.size());
    end
    for (int i = 0; i < ed.size() && i < log_data.size(); i++) begin
      vec_cnt++;
      if (log_data[i] !== ed[i] || log_cyc[i] - t0 != ec[i]) begin
        err_cnt++;
        $display("FAIL tie2_byte%0d: got 0x%02h at +%0d, expected 0x%02h at +%0d",
                 i, log_data[i], log_cyc[i] - t0, ed[i], ec[i]);
      end
    end
    $display("test_tie_round_robin done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    int t0;
    logic [7:0] ed[$];
    int ec[$];
    // Low byte at +2, FIFO full during +3..+7, high byte at +8.
    // The RF byte captured during the stall follows after the IDLE bubble.
    ed = '{8'hFF, 8'h00, 8'h77};
    ec = '{2, 8, 10};
    log_clear();
    t0 = cyc;
    for (int i = 0; i < 14; i++) begin
      alu_out     = 16'h00FF;
      alu_out_vld = (i == 0);
      rf_rd_data  = 8'h77;
      rf_rd_vld   = (i == 4);
      fifo_full   = (i >= 3 && i <= 7);
      tick();
    end
    alu_out_vld = 1'b0; rf_rd_vld = 1'b0; fifo_full = 1'b0;
    vec_cnt++;
    if (log_data.size() != ed.size()) begin
      err_cnt++;
      $display("FAIL bp_count: got %0d writes, expected %0d", log_data.size(), ed.size());
    end
    for (int i = 0; i < ed.size() && i < log_data.size(); i++) begin
      vec_cnt++;
      if (log_data[i] !== ed[i] || log_cyc[i] - t0 != ec[i]) begin
        err_cnt++;
        $display("FAIL bp_byte%0d: got 0x%02h at +%0d, expected 0x%02h at +%0d",
                 i, log_data[i], log_cyc[i] - t0, ed[i], ec[i]);
      end
    end
    $display("test_backpressure done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overflow();
    int t0;
    logic o2, o3;

    // RF 0x11 is held by a full FIFO; RF 0x22 is dropped.
    log_clear();
    t0 = cyc;
    o2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      fifo_full  = (i < 5);
      rf_rd_vld  = (i == 0 || i == 1);
      rf_rd_data = (i == 0) ? 8'h11 : 8'h22;
      if (i == 2) o2 = ovf_err;
      tick();
    end
    rf_rd_vld = 1'b0;
    vec_cnt++;
    if (o2 !== 1'b1) begin
      err_cnt++;
      $display("FAIL ovf_set: got %b, expected 1", o2);
    end
    vec_cnt++;
    if (log_data.size() != 1 || log_data[0] !== 8'h11 || log_cyc[0] - t0 != 5) begin
      err_cnt++;
      $display("FAIL ovf_keep_old: got %0d writes first=0x%02h, expected one 0x11 at +5",
               log_data.size(), (log_data.size() > 0) ? log_data[0] : 8'h00);
    end
    vec_cnt++;
    if (ovf_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL ovf_sticky: got %b, expected 1", ovf_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vec_cnt++;
    if (ovf_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL ovf_clear: got %b, expected 0", ovf_err);
    end

    // err_clr in the same cycle as a new drop: the flag stays set.
    log_clear();
    t0 = cyc;
    o2 = 1'b0; o3 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      fifo_full  = (i < 4);
      rf_rd_vld  = (i <= 2);
      rf_rd_data = 8'h33 + 8'(i * 17);  // 0x33, 0x44, 0x55
      err_clr    = (i == 2);
      if (i == 2) o2 = ovf_err;
      if (i == 3) o3 = ovf_err;
      tick();
    end
    rf_rd_vld = 1'b0; err_clr = 1'b0;
    vec_cnt++;
    if (o2 !== 1'b1 || o3 !== 1'b1) begin
      err_cnt++;
      $display("FAIL ovf_set_wins: got %b then %b, expected 1 then 1", o2, o3);
    end
    vec_cnt++;
    if (log_data.size() != 1 || log_data[0] !== 8'h33 || log_cyc[0] - t0 != 4) begin
      err_cnt++;
      $display("FAIL ovf_keep_old2: got %0d writes first=0x%02h, expected one 0x33 at +4",
               log_data.size(), (log_data.size() > 0) ? log_data[0] : 8'h00);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    $display("test_overflow done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    int t0;
    logic [7:0] d2, d3;
    logic [7:0] ed[$];
    int ec[$];

    // RF recaptured during its own release cycle.
    ed = '{8'h01, 8'h02};
    ec = '{2, 4};
    log_clear();
    t0 = cyc;
    d2 = 8'h00;
    for (int i = 0; i < 7; i++) begin
      rf_rd_vld  = (i == 0 || i == 2);
      rf_rd_data = (i == 0) ? 8'h01 : 8'h02;
      if (i == 2) d2 = fifo_wr_data;
      tick();
    end
    rf_rd_vld = 1'b0;
    vec_cnt++;
    if (d2 !== 8'h01) begin
      err_cnt++;
      $display("FAIL b2b_rf_old_byte: got 0x%02h, expected 0x01", d2);
    end
    vec_cnt++;
    if (log_data.size() != ed.size()) begin
      err_cnt++;
      $display("FAIL b2b_rf_count: got %0d writes, expected %0d", log_data.size(), ed.size());
    end
    for (int i = 0; i < ed.size() && i < log_data.size(); i++) begin
      vec_cnt++;
      if (log_data[i] !== ed[i] || log_cyc[i] - t0 != ec[i]) begin
        err_cnt++;
        $display("FAIL b2b_rf_byte%0d: got 0x%02h at +%0d, expected 0x%02h at +%0d",
                 i, log_data[i], log_cyc[i] - t0, ed[i], ec[i]);
      end
    end

    // ALU recaptured during the high-byte release cycle.
    ed = '{8'h01, 8'h02, 8'h03, 8'h04};
    ec = '{2, 3, 5, 6};
    log_clear();
    t0 = cyc;
    d3 = 8'h00;
    for (int i = 0; i < 9; i++) begin
      alu_out_vld = (i == 0 || i == 3);
      alu_out     = (i == 0) ? 16'h0201 : 16'h0403;
      if (i == 3) d3 = fifo_wr_data;
      tick();
    end
    alu_out_vld = 1'b0;
    vec_cnt++;
    if (d3 !== 8'h02) begin
      err_cnt++;
      $display("FAIL b2b_alu_old_byte: got 0x%02h, expected 0x02", d3);
    end
    vec_cnt++;
    if (log_data.size() != ed.size()) begin
      err_cnt++;
      $display("FAIL b2b_alu_count: got %0d writes, expected %0d", log_data.size(), ed.size());
    end
    for (int i = 0; i < ed.size() && i < log_data.size(); i++) begin
      vec_cnt++;
      if (log_data[i] !== ed[i] || log_cyc[i] - t0 != ec[i]) begin
        err_cnt++;
        $display("FAIL b2b_alu_byte%0d: got 0x%02h at +%0d, expected 0x%02h at +%0d",
                 i, log_data[i], log_cyc[i] - t0, ed[i], ec[i]);
      end
    end
    vec_cnt++;
    if (ovf_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_ovf: got %b, expected 0", ovf_err);
    end
    $display("test_back_to_back done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_op();
    int t0;
    logic [7:0] hi_before;
    log_clear();
    t0 = cyc;
    alu_out = 16'hABCD; alu_out_vld = 1'b1;
    tick();
    alu_out_vld = 1'b0;
    tick();
    tick();
    // Now in SEND_HI; hold it with fifo_full, then reset mid-cycle.
    fifo_full = 1'b1;
    hi_before = fifo_wr_data;
    vec_cnt++;
    if (hi_before !== 8'hAB) begin
      err_cnt++;
      $display("FAIL rstmid_hi_pending: got 0x%02h, expected 0xab", hi_before);
    end
    #2;
    rst = 1'b0;
    #1;
    vec_cnt++;
    if ({fifo_wr_en, fifo_wr_data, busy, ovf_err} !== 11'b0) begin
      err_cnt++;
      $display("FAIL rstmid_outputs: got en=%b data=%h busy=%b ovf=%b, expected all 0",
               fifo_wr_en, fifo_wr_data, busy, ovf_err);
    end
    fifo_full = 1'b0;
    tick();
    rst = 1'b1;
    repeat (5) tick();
    vec_cnt++;
    if (log_data.size() != 1 || log_data[0] !== 8'hCD || log_cyc[0] - t0 != 2) begin
      err_cnt++;
      $display("FAIL rstmid_no_hi: got %0d writes first=0x%02h, expected one 0xcd at +2",
               log_data.size(), (log_data.size() > 0) ? log_data[0] : 8'h00);
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL rstmid_idle: got busy=%b, expected 0", busy);
    end
    $display("test_reset_mid_op done");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_rf_read();
    test_alu_result();
    test_tie_round_robin();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
